data_mem_arbiter: RTL and testbench

- Shares the single data-memory port between the pipeline memory stage (M) and an external loader/DMA requester (X).
- Sequences each access as grant → memory request/ack → registered response.
- Stalls the pipeline while an M access is outstanding.
- Guards against an unresponsive memory with a timeout and a sticky error flag.
- Sits between the memory stage and the data memory wrapper.

---
 rtl/memarb_pkg.sv | 51 +++++
 rtl/memarb_timeout.sv | 33 +++
 rtl/data_mem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memarb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester identity,
// and the latched memory request record.
package memarb_pkg;

    // Width of the address/data fields carried in the latched request.
    localparam int MEMARB_DW = 32;

    // Arbiter sequencing states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_M = 3'd1,
        BUSY_X = 3'd2,
        DONE_M = 3'd3,
        DONE_X = 3'd4
    } arb_state_t;

    // Which requester owns a grant.
    typedef enum logic {
        REQ_M = 1'b0,
        REQ_X = 1'b1
    } req_src_t;

    // Request fields captured at grant time and replayed to memory while busy.
    typedef struct packed {
        logic                 we;
        logic [MEMARB_DW-1:0] addr;
        logic [MEMARB_DW-1:0] wdata;
        logic [2:0]           ctrl;
    } mem_req_t;

    // Assemble a request record from individual fields.
    function automatic mem_req_t build_req(
        input logic                 we,
        input logic [MEMARB_DW-1:0] addr,
        input logic [MEMARB_DW-1:0] wdata,
        input logic [2:0]           ctrl
    );
        mem_req_t r;
        r.we    = we;
        r.addr  = addr;
        r.wdata = wdata;
        r.ctrl  = ctrl;
        return r;
    endfunction

    // True while a memory access is in flight.
    function automatic logic is_busy(input arb_state_t s);
        return (s == BUSY_M) || (s == BUSY_X);
    endfunction

endpackage

// File: rtl/memarb_timeout.sv
// 8-bit watchdog counter for an outstanding memory access. Counts enabled
// cycles, clears on request, and flags when the last allowed cycle is reached.
module memarb_timeout #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    // The final waiting cycle is the one where the count equals MEM_TIMEOUT-1.
    localparam logic [7:0] LIMIT_M1 = 8'(MEM_TIMEOUT - 1);

    logic [7:0] r_cnt;

    // Cycle counter: clear has priority over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (i_clr) begin
            r_cnt <= 8'd0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 8'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expired = (r_cnt == LIMIT_M1);

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbiter sharing the single data-memory port between the pipeline memory
// stage (M) and an external loader/DMA requester (X). Each access runs
// IDLE (grant) -> BUSY (request until ack or timeout) -> DONE (response).
module data_mem_arbiter
    import memarb_pkg::*;
#(
    parameter int DATA_WIDTH   = MEMARB_DW,
    parameter int STARVE_LIMIT = 4,
    parameter int MEM_TIMEOUT  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    // Pipeline memory stage
    input  logic                  MemReqM,
    input  logic                  MemWriteM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [2:0]            AddressingControlM,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallM,
    // External requester
    input  logic                  XReqValid,
    output logic                  XReqReady,
    input  logic                  XWrite,
    input  logic [DATA_WIDTH-1:0] XAddr,
    input  logic [DATA_WIDTH-1:0] XWData,
    input  logic [2:0]            XAddressingControl,
    output logic                  XRspValid,
    output logic [DATA_WIDTH-1:0] XRData,
    // Data memory
    output logic                  MemReq,
    output logic                  MemWE,
    output logic [DATA_WIDTH-1:0] MemA,
    output logic [DATA_WIDTH-1:0] MemWD,
    output logic [2:0]            MemAddrCtrl,
    input  logic [DATA_WIDTH-1:0] MemRD,
    input  logic                  MemAck,
    // Status
    output logic                  ErrFlag
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    // Registered state
    arb_state_t            r_state;
    logic [3:0]            r_starve_cnt;
    mem_req_t              r_req;
    logic                  r_mem_req;
    logic                  r_xrsp_valid;
    logic                  r_err_flag;
    logic [DATA_WIDTH-1:0] r_read_data_m;
    logic [DATA_WIDTH-1:0] r_xrdata;

    // Combinational decode
    logic                  w_grant_vld;
    req_src_t              w_grant_src;
    mem_req_t              w_sel_req;
    logic                  w_busy;
    logic                  w_finish;
    logic                  w_tmo_en;
    logic                  w_tmo_clr;
    logic                  w_tmo_expired;

    // IDLE grant decision: X wins when M is quiet or M has starved X long enough.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_src = REQ_M;
        if (r_state == IDLE) begin
            if (XReqValid && (!MemReqM || (r_starve_cnt == STARVE_LIM))) begin
                w_grant_vld = 1'b1;
                w_grant_src = REQ_X;
            end else if (MemReqM) begin
                w_grant_vld = 1'b1;
                w_grant_src = REQ_M;
            end else begin
                w_grant_vld = 1'b0;
                w_grant_src = REQ_M;
            end
        end else begin
            w_grant_vld = 1'b0;
            w_grant_src = REQ_M;
        end
    end

    // Select the request fields of the requester being granted.
    always_comb begin
        w_sel_req = '0;
        if (w_grant_src == REQ_X) begin
            w_sel_req = build_req(XWrite, XAddr, XWData, XAddressingControl);
        end else begin
            w_sel_req = build_req(MemWriteM, ALUResultM, WriteDataM, AddressingControlM);
        end
    end

    // An access ends on ack, or on the last permitted cycle without ack.
    assign w_busy    = is_busy(r_state);
    assign w_finish  = w_busy && (MemAck || w_tmo_expired);
    assign w_tmo_en  = w_busy && !MemAck;
    assign w_tmo_clr = !w_busy || w_finish;

    memarb_timeout #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_tmo_clr),
        .i_en      (w_tmo_en),
        .o_expired (w_tmo_expired)
    );

    // Main sequencer: grant, memory handshake, response capture, error latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_starve_cnt  <= 4'd0;
            r_req         <= '0;
            r_mem_req     <= 1'b0;
            r_xrsp_valid  <= 1'b0;
            r_err_flag    <= 1'b0;
            r_read_data_m <= '0;
            r_xrdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_xrsp_valid <= 1'b0;
                    if (w_grant_vld) begin
                        r_req     <= w_sel_req;
                        r_mem_req <= 1'b1;
                        if (w_grant_src == REQ_X) begin
                            r_state      <= BUSY_X;
                            r_starve_cnt <= 4'd0;
                        end else begin
                            r_state <= BUSY_M;
                            // Only count M grants that actually made X wait.
                            if (XReqValid && (r_starve_cnt != STARVE_LIM)) begin
                                r_starve_cnt <= r_starve_cnt + 4'd1;
                            end else begin
                                r_starve_cnt <= r_starve_cnt;
                            end
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BUSY_M: begin
                    if (MemAck) begin
                        r_read_data_m <= MemRD;
                        r_mem_req     <= 1'b0;
                        r_state       <= DONE_M;
                    end else if (w_tmo_expired) begin
                        r_read_data_m <= '0;
                        r_err_flag    <= 1'b1;
                        r_mem_req     <= 1'b0;
                        r_state       <= DONE_M;
                    end else begin
                        r_state <= BUSY_M;
                    end
                end
                BUSY_X: begin
                    if (MemAck) begin
                        r_xrdata     <= MemRD;
                        r_mem_req    <= 1'b0;
                        r_xrsp_valid <= 1'b1;
                        r_state      <= DONE_X;
                    end else if (w_tmo_expired) begin
                        r_xrdata     <= '0;
                        r_err_flag   <= 1'b1;
                        r_mem_req    <= 1'b0;
                        r_xrsp_valid <= 1'b1;
                        r_state      <= DONE_X;
                    end else begin
                        r_state <= BUSY_X;
                    end
                end
                DONE_M: begin
                    r_state <= IDLE;
                end
                DONE_X: begin
                    // Response pulse lasts exactly this one cycle.
                    r_xrsp_valid <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state      <= IDLE;
                    r_mem_req    <= 1'b0;
                    r_xrsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Memory-side outputs replay the latched request; write enable only
    // means anything alongside an active request, so it is gated by it.
    assign MemReq      = r_mem_req;
    assign MemWE       = r_mem_req & r_req.we;
    assign MemA        = r_req.addr;
    assign MemWD       = r_req.wdata;
    assign MemAddrCtrl = r_req.ctrl;

    // Requester-side outputs.
    assign ReadDataM = r_read_data_m;
    assign XRData    = r_xrdata;
    assign XRspValid = r_xrsp_valid;
    assign ErrFlag   = r_err_flag;
    assign XReqReady = w_grant_vld && (w_grant_src == REQ_X);

    // The pipeline is released only in the cycle its result is presented.
    assign StallM = MemReqM && (r_state != DONE_M);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed, table-driven bench for data_mem_arbiter with hand sequences for
// starvation, timeout and mid-access reset.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemReqM = 1'b0, MemWriteM = 1'b0;
    logic [31:0] ALUResultM = 32'h0, WriteDataM = 32'h0;
    logic [2:0]  AddressingControlM = 3'b0;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        XReqValid = 1'b0, XReqReady, XWrite = 1'b0;
    logic [31:0] XAddr = 32'h0, XWData = 32'h0;
    logic [2:0]  XAddressingControl = 3'b0;
    logic        XRspValid;
    logic [31:0] XRData;
    logic        MemReq, MemWE;
    logic [31:0] MemA, MemWD;
    logic [2:0]  MemAddrCtrl;
    logic [31:0] MemRD = 32'h0;
    logic        MemAck = 1'b0;
    logic        ErrFlag;

    int n_checks = 0;
    int n_pass   = 0;

    data_mem_arbiter #(
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (4),
        .MEM_TIMEOUT  (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .MemReqM            (MemReqM),
        .MemWriteM          (MemWriteM),
        .ALUResultM         (ALUResultM),
        .WriteDataM         (WriteDataM),
        .AddressingControlM (AddressingControlM),
        .ReadDataM          (ReadDataM),
        .StallM             (StallM),
        .XReqValid          (XReqValid),
        .XReqReady          (XReqReady),
        .XWrite             (XWrite),
        .XAddr              (XAddr),
        .XWData             (XWData),
        .XAddressingControl (XAddressingControl),
        .XRspValid          (XRspValid),
        .XRData             (XRData),
        .MemReq             (MemReq),
        .MemWE              (MemWE),
        .MemA               (MemA),
        .MemWD              (MemWD),
        .MemAddrCtrl        (MemAddrCtrl),
        .MemRD              (MemRD),
        .MemAck             (MemAck),
        .ErrFlag            (ErrFlag)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        is_x;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ctrl;
        int          ack_cyc;   // BUSY cycle (1-based) carrying MemAck; 0 = never
        logic [31:0] rdata;
        logic [31:0] exp_rd;
        int          exp_busy;
        logic        exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access from the IDLE grant cycle through the return to IDLE.
    task automatic run_vec(input vec_t v);
        int busy;
        int stall;
        bit done;
        busy  = 0;
        stall = 0;
        done  = 0;
        tick();
        MemReqM            = !v.is_x;
        MemWriteM          = v.we;
        ALUResultM         = v.addr;
        WriteDataM         = v.wdata;
        AddressingControlM = v.ctrl;
        XReqValid          = v.is_x;
        XWrite             = v.we;
        XAddr              = v.addr;
        XWData             = v.wdata;
        XAddressingControl = v.ctrl;
        MemAck             = 1'b0;
        MemRD              = 32'hFFFF_FFFF;
        @(negedge clk);
        check1({v.name, "_xready"}, XReqReady, v.is_x);
        check1({v.name, "_idle_stall"}, StallM, !v.is_x);
        if (StallM) stall++;
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            XReqValid = 1'b0;
            MemAck    = ((busy + 1) == v.ack_cyc);
            MemRD     = MemAck ? v.rdata : 32'hFFFF_FFFF;
            @(negedge clk);
            if (MemReq) begin
                busy++;
                if (StallM) stall++;
                check1({v.name, "_we"}, MemWE, v.we);
                check32({v.name, "_ctrl"}, {29'd0, MemAddrCtrl}, {29'd0, v.ctrl});
                if (busy == 1) begin
                    check32({v.name, "_addr"}, MemA, v.addr);
                    check32({v.name, "_wdata"}, MemWD, v.wdata);
                end
            end else begin
                done = 1;
                if (v.is_x) begin
                    check1({v.name, "_rspvalid"}, XRspValid, 1'b1);
                    check32({v.name, "_xrdata"}, XRData, v.exp_rd);
                end else begin
                    check1({v.name, "_done_stall"}, StallM, 1'b0);
                    check32({v.name, "_rdm"}, ReadDataM, v.exp_rd);
                end
                check1({v.name, "_err"}, ErrFlag, v.exp_err);
            end
        end
        check1({v.name, "_completed"}, done, 1'b1);
        check_int({v.name, "_busy_cycles"}, busy, v.exp_busy);
        if (!v.is_x) check_int({v.name, "_stall_cycles"}, stall, v.exp_busy + 1);
        tick();
        MemReqM = 1'b0;
        MemAck  = 1'b0;
        @(negedge clk);
        check1({v.name, "_rsp_one_cycle"}, XRspValid, 1'b0);
        check1({v.name, "_memreq_idle"}, MemReq, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_grant [10];
        int          g;
        int          xr;
        int          xs;
        logic        prev_req;

        vecs[0] = '{"m_load",   1'b0, 1'b0, 32'h0000_0040, 32'h1111_1111, 3'b010, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1,  1'b0};
        vecs[1] = '{"x_write",  1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678, 3'b010, 1, 32'hAAAA_5555, 32'hAAAA_5555, 1,  1'b0};
        vecs[2] = '{"m_store",  1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 3'b000, 3, 32'h0BAD_F00D, 32'h0BAD_F00D, 3,  1'b0};
        vecs[3] = '{"x_read",   1'b1, 1'b0, 32'h0000_0300, 32'h0000_0000, 3'b101, 2, 32'h8765_4321, 32'h8765_4321, 2,  1'b0};
        vecs[4] = '{"m_load2",  1'b0, 1'b0, 32'h0000_0404, 32'h0000_0000, 3'b001, 1, 32'h1357_9BDF, 32'h1357_9BDF, 1,  1'b0};
        vecs[5] = '{"m_tmo",    1'b0, 1'b0, 32'h0000_0500, 32'h0000_0000, 3'b010, 0, 32'h0000_0000, 32'h0000_0000, 16, 1'b1};

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check1("rst_memreq", MemReq, 1'b0);
        check1("rst_rspvalid", XRspValid, 1'b0);
        check1("rst_xready", XReqReady, 1'b0);
        check1("rst_err", ErrFlag, 1'b0);
        check32("rst_rdm", ReadDataM, 32'h0);
        check32("rst_xrdata", XRData, 32'h0);
        check32("rst_mema", MemA, 32'h0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Error flag is sticky across idle cycles.
        repeat (3) tick();
        @(negedge clk);
        check1("err_sticky", ErrFlag, 1'b1);

        // Reset in the second BUSY_X cycle abandons the access.
        tick();
        XReqValid = 1'b1;
        XWrite    = 1'b0;
        XAddr     = 32'h0000_0600;
        MemAck    = 1'b0;
        @(negedge clk);
        check1("rstx_xready", XReqReady, 1'b1);
        tick();
        XReqValid = 1'b0;
        @(negedge clk);
        check1("rstx_busy1", MemReq, 1'b1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check1("rstx_busy2", MemReq, 1'b1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check1("rstx_memreq", MemReq, 1'b0);
        check1("rstx_memwe", MemWE, 1'b0);
        check1("rstx_rspvalid", XRspValid, 1'b0);
        check1("rstx_err", ErrFlag, 1'b0);
        check32("rstx_xrdata", XRData, 32'h0);
        check32("rstx_rdm", ReadDataM, 32'h0);
        check32("rstx_mema", MemA, 32'h0);
        xs = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            @(negedge clk);
            if (XRspValid || MemReq) xs++;
        end
        check_int("rstx_no_rsp", xs, 0);

        // Both requesters continuously active with immediate acks.
        for (int i = 0; i < 10; i++) exp_grant[i] = ((i % 5) == 4) ? 32'h0000_00B0 : 32'h0000_00A0;
        g        = 0;
        xr       = 0;
        xs       = 0;
        prev_req = 1'b0;
        tick();
        MemReqM    = 1'b1;
        MemWriteM  = 1'b0;
        ALUResultM = 32'h0000_00A0;
        XReqValid  = 1'b1;
        XWrite     = 1'b0;
        XAddr      = 32'h0000_00B0;
        MemRD      = 32'h5A5A_A5A5;
        @(negedge clk);
        if (XReqReady) xr++;
        for (int c = 0; c < 60 && g < 10; c++) begin
            tick();
            MemAck = MemReq;
            @(negedge clk);
            if (XReqReady) xr++;
            if (XRspValid) xs++;
            if (MemReq && !prev_req) begin
                check32($sformatf("starve_grant%0d", g), MemA, exp_grant[g]);
                g++;
            end
            prev_req = MemReq;
        end
        check_int("starve_grant_count", g, 10);
        check_int("starve_xready_pulses", xr, 2);
        MemReqM   = 1'b0;
        XReqValid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            MemAck = MemReq;
            @(negedge clk);
            if (XRspValid) xs++;
        end
        check_int("starve_xrsp_pulses", xs, 2);
        check32("starve_last_xrdata", XRData, 32'h5A5A_A5A5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
